// File: rtl/tt_ihp_pad_cfg_ctrl.sv
// Runtime pad-ring configuration for the IHP SG13G2 GPIO ring: shadow/active mode banks,
// atomic commit through a forced hi-Z settle window, input synchronisers and per-mode OE gating.
module tt_ihp_pad_cfg_ctrl #(
    parameter int                        N_PADS      = 64,
    parameter int                        MODE_W      = 4,
    parameter int                        SETTLE_CYC  = 4,
    parameter int                        SYNC_STAGES = 2,
    parameter logic [N_PADS*MODE_W-1:0]  RST_MODE    = {N_PADS{4'b0110}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [7:0]                   cfg_pad,
    input  logic [MODE_W-1:0]            cfg_mode,
    input  logic                         cfg_commit,
    output logic                         busy,
    output logic                         cfg_err,
    output logic [N_PADS*MODE_W-1:0]     pad_mode,
    input  logic [N_PADS-1:0]            pad_in_raw,
    output logic [N_PADS-1:0]            pad_in_sync,
    input  logic [N_PADS-1:0]            pad_oe_core,
    output logic [N_PADS-1:0]            pad_oe_gated
);

    localparam logic [MODE_W-1:0] MODE_OUT   = MODE_W'(4'b1001);
    localparam logic [MODE_W-1:0] MODE_IN    = MODE_W'(4'b1010);
    localparam logic [MODE_W-1:0] MODE_BIDIR = MODE_W'(4'b1011);
    localparam logic [8:0]        PAD_LIMIT  = 9'(N_PADS);

    typedef enum logic [1:0] {
        IDLE,
        HIZ,
        APPLY
    } state_t;

    state_t                      state;
    logic [7:0]                  settle_cnt;
    logic                        busy_q;
    logic                        force_hiz;
    logic [N_PADS*MODE_W-1:0]    shadow;
    logic [N_PADS*MODE_W-1:0]    active;
    logic [N_PADS-1:0]           sync_q [SYNC_STAGES];
    logic                        write_en;
    logic                        pad_ok;

    assign write_en  = cfg_valid & ~busy_q;
    assign pad_ok    = ({1'b0, cfg_pad} < PAD_LIMIT);
    assign cfg_ready = ~busy_q;
    assign busy      = busy_q;
    assign pad_mode  = active;

    // Shadow bank accepts writes only while idle; out-of-range indices raise a sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= RST_MODE;
            cfg_err <= 1'b0;
        end else if (write_en) begin
            if (!pad_ok) begin
                cfg_err <= 1'b1;
            end
            for (int i = 0; i < N_PADS; i++) begin
                if (cfg_pad == 8'(i)) begin
                    shadow[i*MODE_W +: MODE_W] <= cfg_mode;
                end
            end
        end
    end

    // Commit sequencer: pads are held hi-Z for SETTLE_CYC cycles, then one APPLY cycle
    // copies shadow to active so pad_mode and OE release change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            busy_q     <= 1'b0;
            force_hiz  <= 1'b0;
            active     <= RST_MODE;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_commit) begin
                        state      <= HIZ;
                        settle_cnt <= 8'(SETTLE_CYC - 1);
                        busy_q     <= 1'b1;
                        force_hiz  <= 1'b1;
                    end
                end
                HIZ: begin
                    if (settle_cnt == 8'd0) begin
                        state <= APPLY;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                APPLY: begin
                    active    <= shadow;
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    force_hiz <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    force_hiz <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Gating follows the active bank only, so a pending shadow write never leaks to the pads.
    always_comb begin
        pad_oe_gated = '0;
        pad_in_sync  = '0;
        for (int i = 0; i < N_PADS; i++) begin
            pad_oe_gated[i] = pad_oe_core[i] & ~force_hiz &
                              ((active[i*MODE_W +: MODE_W] == MODE_OUT) ||
                               (active[i*MODE_W +: MODE_W] == MODE_BIDIR));
            pad_in_sync[i]  = sync_q[SYNC_STAGES-1][i] &
                              ((active[i*MODE_W +: MODE_W] == MODE_IN) ||
                               (active[i*MODE_W +: MODE_W] == MODE_BIDIR));
        end
    end

endmodule

// File: tb/tb_tt_ihp_pad_cfg_ctrl.sv
// Directed self-checking bench for tt_ihp_pad_cfg_ctrl with default parameters
// (64 pads, 4-bit modes, 4 settle cycles, 2 sync stages).
module tb_tt_ihp_pad_cfg_ctrl;

    localparam int N_PADS = 64;
    localparam int MODE_W = 4;
    localparam logic [N_PADS*MODE_W-1:0] RST_VEC = {N_PADS{4'b0110}};

    logic                      clk;
    logic                      rst;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [7:0]                cfg_pad;
    logic [MODE_W-1:0]         cfg_mode;
    logic                      cfg_commit;
    logic                      busy;
    logic                      cfg_err;
    logic [N_PADS*MODE_W-1:0]  pad_mode;
    logic [N_PADS-1:0]         pad_in_raw;
    logic [N_PADS-1:0]         pad_in_sync;
    logic [N_PADS-1:0]         pad_oe_core;
    logic [N_PADS-1:0]         pad_oe_gated;

    logic [N_PADS*MODE_W-1:0]  exp_mode;
    int compared;
    int mismatched;

    tt_ihp_pad_cfg_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_pad      (cfg_pad),
        .cfg_mode     (cfg_mode),
        .cfg_commit   (cfg_commit),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .pad_mode     (pad_mode),
        .pad_in_raw   (pad_in_raw),
        .pad_in_sync  (pad_in_sync),
        .pad_oe_core  (pad_oe_core),
        .pad_oe_gated (pad_oe_gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic do_write(input logic [7:0] pad, input logic [3:0] mode);
        cfg_valid = 1'b1;
        cfg_pad   = pad;
        cfg_mode  = mode;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_mode = RST_VEC;
        compared++;
        if (pad_mode !== exp_mode) begin
            mismatched++;
            $display("[TB] FAIL reset_pad_mode: got %h required %h", pad_mode, exp_mode);
        end
        compared++;
        if (pad_oe_gated !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_oe_gated: got %h required 0", pad_oe_gated);
        end
        compared++;
        if (pad_in_sync !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_sync: got %h required 0", pad_in_sync);
        end
        compared++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: busy=%b ready=%b err=%b required 0 1 0", busy, cfg_ready, cfg_err);
        end
    endtask

    task automatic test_commit_timing();
        do_write(8'd9, 4'b1001);
        compared++;
        if (pad_mode[39:36] !== 4'b0110) begin
            mismatched++;
            $display("[TB] FAIL shadow_leak_pad9: got %b required 0110", pad_mode[39:36]);
        end
        do_commit();
        for (int c = 0; c < 5; c++) begin
            compared++;
            if (busy !== 1'b1 || pad_oe_gated[9] !== 1'b0 || pad_mode[39:36] !== 4'b0110) begin
                mismatched++;
                $display("[TB] FAIL commit_window_c%0d: busy=%b oe9=%b mode9=%b required 1 0 0110",
                         c, busy, pad_oe_gated[9], pad_mode[39:36]);
            end
            @(negedge clk);
        end
        exp_mode[39:36] = 4'b1001;
        compared++;
        if (busy !== 1'b0 || pad_mode[39:36] !== 4'b1001 || pad_oe_gated[9] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL commit_applied: busy=%b mode9=%b oe9=%b required 0 1001 1",
                     busy, pad_mode[39:36], pad_oe_gated[9]);
        end
        compared++;
        if (pad_oe_gated !== 64'h0000_0000_0000_0200) begin
            mismatched++;
            $display("[TB] FAIL oe_gated_vector: got %h required 0000000000000200", pad_oe_gated);
        end
    endtask

    task automatic test_input_sync();
        do_write(8'd41, 4'b1010);
        do_commit();
        wait_idle("sync_commit");
        exp_mode[167:164] = 4'b1010;
        compared++;
        if (pad_oe_gated[41] !== 1'b0 || pad_mode[167:164] !== 4'b1010) begin
            mismatched++;
            $display("[TB] FAIL in_only_oe41: oe=%b mode=%b required 0 1010", pad_oe_gated[41], pad_mode[167:164]);
        end
        pad_in_raw[41] = 1'b1;
        @(negedge clk);
        compared++;
        if (pad_in_sync[41] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sync_rise_edge1: got %b required 0", pad_in_sync[41]);
        end
        @(negedge clk);
        compared++;
        if (pad_in_sync[41] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sync_rise_edge2: got %b required 1", pad_in_sync[41]);
        end
        pad_in_raw[41] = 1'b0;
        @(negedge clk);
        compared++;
        if (pad_in_sync[41] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sync_fall_edge1: got %b required 1", pad_in_sync[41]);
        end
        @(negedge clk);
        compared++;
        if (pad_in_sync[41] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sync_fall_edge2: got %b required 0", pad_in_sync[41]);
        end
        pad_in_raw[41] = 1'b1;
        repeat (2) @(negedge clk);
        do_write(8'd41, 4'b1100);
        do_commit();
        compared++;
        if (pad_in_sync[41] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sync_during_hiz: got %b required 1", pad_in_sync[41]);
        end
        wait_idle("sync_recommit");
        exp_mode[167:164] = 4'b1100;
        compared++;
        if (pad_in_sync[41] !== 1'b0 || pad_mode !== exp_mode) begin
            mismatched++;
            $display("[TB] FAIL sync_gated_1100: sync=%b mode41=%b required 0 1100", pad_in_sync[41], pad_mode[167:164]);
        end
        pad_in_raw[41] = 1'b0;
    endtask

    task automatic test_cfg_err();
        compared++;
        if (cfg_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_before: got %b required 0", cfg_err);
        end
        do_write(8'd70, 4'b1001);
        compared++;
        if (cfg_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_set: got %b required 1", cfg_err);
        end
        do_commit();
        wait_idle("err_commit");
        compared++;
        if (cfg_err !== 1'b1 || pad_mode !== exp_mode) begin
            mismatched++;
            $display("[TB] FAIL err_sticky_shadow: err=%b mode=%h required 1 %h", cfg_err, pad_mode, exp_mode);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_pad    = 8'd3;
        cfg_mode   = 4'b1011;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            if (n == 1) begin
                cfg_commit = 1'b1;
                cfg_valid  = 1'b1;
                cfg_pad    = 8'd4;
                cfg_mode   = 4'b1001;
                compared++;
                if (cfg_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL ready_while_busy: got %b required 0", cfg_ready);
                end
            end else begin
                cfg_commit = 1'b0;
                cfg_valid  = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        cfg_commit = 1'b0;
        cfg_valid  = 1'b0;
        compared++;
        if (n !== 5) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy_len: got %0d cycles required 5", n);
        end
        exp_mode[15:12] = 4'b1011;
        compared++;
        if (pad_mode !== exp_mode || pad_oe_gated[3] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_modes: mode=%h oe3=%b required %h 1", pad_mode, pad_oe_gated[3], exp_mode);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_no_queue: busy=%b required 0", busy);
        end
        do_commit();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        compared++;
        if (n !== 5 || pad_mode !== exp_mode) begin
            mismatched++;
            $display("[TB] FAIL unchanged_commit: cycles=%0d mode4=%b required 5 0110", n, pad_mode[19:16]);
        end
    endtask

    task automatic test_reset_mid_commit();
        do_write(8'd5, 4'b1001);
        do_commit();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_mode = RST_VEC;
        compared++;
        if (busy !== 1'b0 || pad_mode !== exp_mode || cfg_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_commit: busy=%b err=%b mode=%h required 0 0 %h", busy, cfg_err, pad_mode, exp_mode);
        end
        compared++;
        if (pad_oe_gated !== '0 || cfg_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_oe: oe=%h ready=%b required 0 1", pad_oe_gated, cfg_ready);
        end
        do_commit();
        wait_idle("post_rst_commit");
        compared++;
        if (pad_mode[23:20] !== 4'b0110 || pad_mode !== exp_mode) begin
            mismatched++;
            $display("[TB] FAIL post_rst_pad5: got %b required 0110", pad_mode[23:20]);
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pad     = 8'd0;
        cfg_mode    = 4'd0;
        cfg_commit  = 1'b0;
        pad_in_raw  = '0;
        pad_oe_core = '1;
        exp_mode    = RST_VEC;
        @(negedge clk);
        test_reset();
        test_commit_timing();
        test_input_sync();
        test_cfg_err();
        test_back_to_back();
        test_reset_mid_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
